// File: rtl/io_periph_bus.sv
// Memory-mapped IO register block: GPIO bank, SPI port with chip selects, UART registers with RX FIFO.
// States: IDLE = accept request | SPI_WAIT = SPI engine busy | TX_WAIT = stalled on tx_busy | DONE = hold request_done
module io_periph_bus #(
   parameter int GPIO_W   = 8,
   parameter int NUM_CS   = 4,
   parameter int RX_DEPTH = 4,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_request,
   input  logic              is_write,
   input  logic [ADDR_W-1:0] target_address,
   input  logic [31:0]       write_value,
   output logic [31:0]       fetched_value,
   output logic              request_done,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic [NUM_CS-1:0] spi_cs_n,
   output logic              spi_start,
   output logic [7:0]        spi_tx_byte,
   input  logic              spi_done,
   input  logic [7:0]        spi_rx_byte,
   output logic              uart_tx_start,
   output logic [7:0]        uart_tx_byte,
   input  logic              uart_tx_done,
   input  logic              uart_rx_valid,
   input  logic [7:0]        uart_rx_byte
);

   localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam logic [ADDR_W-3:0] W_GPIO_OUT  = (ADDR_W-2)'(0);
   localparam logic [ADDR_W-3:0] W_GPIO_OE   = (ADDR_W-2)'(1);
   localparam logic [ADDR_W-3:0] W_GPIO_IN   = (ADDR_W-2)'(2);
   localparam logic [ADDR_W-3:0] W_SPI_CS    = (ADDR_W-2)'(3);
   localparam logic [ADDR_W-3:0] W_SPI_DATA  = (ADDR_W-2)'(4);
   localparam logic [ADDR_W-3:0] W_UART_STAT = (ADDR_W-2)'(5);
   localparam logic [ADDR_W-3:0] W_UART_TX   = (ADDR_W-2)'(6);
   localparam logic [ADDR_W-3:0] W_UART_RX   = (ADDR_W-2)'(7);

   typedef enum logic [1:0] {IDLE, SPI_WAIT, TX_WAIT, DONE} state_t;
   state_t state, state_nx;

   logic [ADDR_W-3:0] waddr;
   logic [GPIO_W-1:0] gpio_out_r, gpio_oe_r, gpio_meta, gpio_sync;
   logic [NUM_CS-1:0] cs_mask;
   logic              cs_hold;
   logic [7:0]        spi_rx_last, pend_byte, tx_byte_nx;
   logic              tx_busy, overflow;
   logic [31:0]       rdata_r, rd_mux;
   logic              acc, tx_go, spi_go, to_txwait, rx_cap;
   logic              wr_acc, rd_acc, pop, push, ovf_set;
   logic [7:0]        fifo_mem [RX_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              fifo_empty, fifo_full;
   logic              unused_bits;

   assign waddr       = target_address[ADDR_W-1:2];
   assign unused_bits = ^{write_value, target_address};

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign wr_acc  = acc && is_write;
   assign rd_acc  = acc && !is_write;
   assign pop     = rd_acc && (waddr == W_UART_RX) && !fifo_empty;
   assign push    = uart_rx_valid && (!fifo_full || pop);
   assign ovf_set = uart_rx_valid && fifo_full && !pop;

   always_comb begin
      state_nx  = state;
      acc       = 1'b0;
      tx_go     = 1'b0;
      spi_go    = 1'b0;
      to_txwait = 1'b0;
      rx_cap    = 1'b0;
      case (state)
         IDLE: if (start_request) begin
            if (is_write && waddr == W_SPI_DATA) begin
               spi_go   = 1'b1;
               state_nx = SPI_WAIT;
            end else if (is_write && waddr == W_UART_TX && tx_busy) begin
               to_txwait = 1'b1;
               state_nx  = TX_WAIT;
            end else begin
               acc      = 1'b1;
               tx_go    = is_write && (waddr == W_UART_TX);
               state_nx = DONE;
            end
         end
         SPI_WAIT: if (spi_done) begin
            rx_cap   = 1'b1;
            state_nx = DONE;
         end
         TX_WAIT: if (!tx_busy) begin
            tx_go    = 1'b1;
            state_nx = DONE;
         end
         DONE: if (!start_request) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (waddr)
         W_GPIO_OUT:  rd_mux = 32'(gpio_out_r);
         W_GPIO_OE:   rd_mux = 32'(gpio_oe_r);
         W_GPIO_IN:   rd_mux = 32'(gpio_sync & ~gpio_oe_r);
         W_SPI_CS: begin
            rd_mux[NUM_CS-1:0] = cs_mask;
            rd_mux[31]         = cs_hold;
         end
         W_SPI_DATA:  rd_mux = {24'h0, spi_rx_last};
         W_UART_STAT: rd_mux = {28'h0, overflow, fifo_full, !fifo_empty, tx_busy};
         W_UART_TX:   rd_mux = {24'h0, uart_tx_byte};
         W_UART_RX:   if (!fifo_empty) rd_mux = {24'h0, fifo_mem[rd_ptr[AW-1:0]]};
         default:     rd_mux = '0;
      endcase
   end

   // A stalled write sends the byte captured on entry, not whatever is on the bus later
   assign tx_byte_nx = (state == TX_WAIT) ? pend_byte : write_value[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         gpio_out_r    <= '0;
         gpio_oe_r     <= '0;
         gpio_meta     <= '0;
         gpio_sync     <= '0;
         cs_mask       <= '0;
         cs_hold       <= 1'b0;
         spi_tx_byte   <= '0;
         spi_rx_last   <= '0;
         pend_byte     <= '0;
         uart_tx_byte  <= '0;
         uart_tx_start <= 1'b0;
         tx_busy       <= 1'b0;
         overflow      <= 1'b0;
         rdata_r       <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
      end else begin
         state         <= state_nx;
         gpio_meta     <= gpio_in;
         gpio_sync     <= gpio_meta;
         uart_tx_start <= tx_go;
         if (state == IDLE && start_request) rdata_r <= rd_acc ? rd_mux : '0;
         if (wr_acc && waddr == W_GPIO_OUT) gpio_out_r <= write_value[GPIO_W-1:0];
         if (wr_acc && waddr == W_GPIO_OE)  gpio_oe_r  <= write_value[GPIO_W-1:0];
         if (wr_acc && waddr == W_SPI_CS) begin
            cs_mask <= write_value[NUM_CS-1:0];
            cs_hold <= write_value[31];
         end
         if (spi_go)    spi_tx_byte <= write_value[7:0];
         if (rx_cap)    spi_rx_last <= spi_rx_byte;
         if (to_txwait) pend_byte   <= write_value[7:0];
         if (tx_go)     uart_tx_byte <= tx_byte_nx;
         if (tx_go)             tx_busy <= 1'b1;
         else if (uart_tx_done) tx_busy <= 1'b0;
         if (ovf_set) overflow <= 1'b1;
         else if (wr_acc && waddr == W_UART_STAT && write_value[3]) overflow <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= uart_rx_byte;
   end

   assign fetched_value = rdata_r;
   assign request_done  = (state == DONE);
   assign spi_start     = (state == SPI_WAIT);
   assign gpio_out      = gpio_out_r & gpio_oe_r;
   assign gpio_oe       = gpio_oe_r;
   assign spi_cs_n      = ~(cs_mask & {NUM_CS{cs_hold | spi_start}});

endmodule

// File: tb/tb_io_periph_bus.sv
// Directed bench for io_periph_bus: GPIO, SPI chip selects, UART TX stall, RX FIFO edges, async reset.
module tb_io_periph_bus;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_request, is_write;
   logic [7:0]  target_address;
   logic [31:0] write_value, fetched_value;
   logic        request_done;
   logic [7:0]  gpio_in, gpio_out, gpio_oe;
   logic [3:0]  spi_cs_n;
   logic        spi_start, spi_done;
   logic [7:0]  spi_tx_byte, spi_rx_byte;
   logic        uart_tx_start, uart_tx_done, uart_rx_valid;
   logic [7:0]  uart_tx_byte, uart_rx_byte;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] rd;
   logic        last_tx_start;

   io_periph_bus dut (
      .clk(clk), .rst_n(rst_n),
      .start_request(start_request), .is_write(is_write),
      .target_address(target_address), .write_value(write_value),
      .fetched_value(fetched_value), .request_done(request_done),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
      .spi_cs_n(spi_cs_n), .spi_start(spi_start), .spi_tx_byte(spi_tx_byte),
      .spi_done(spi_done), .spi_rx_byte(spi_rx_byte),
      .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte),
      .uart_tx_done(uart_tx_done), .uart_rx_valid(uart_rx_valid),
      .uart_rx_byte(uart_rx_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
      int n = 0;
      start_request = 1'b1; is_write = wr; target_address = addr; write_value = wdata;
      do begin
         @(negedge clk);
         n++;
      end while (request_done !== 1'b1 && n < 50);
      chk("bus_done", 32'(request_done), 32'h1);
      rdata = fetched_value;
      last_tx_start = uart_tx_start;
      start_request = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      bus(1'b1, addr, wdata, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, addr, 32'h0, r);
      chk(tag, r, exp);
   endtask

   task automatic push(input logic [7:0] b);
      uart_rx_valid = 1'b1; uart_rx_byte = b;
      @(negedge clk);
      uart_rx_valid = 1'b0;
   endtask

   task automatic rx_read_push(input logic [7:0] b, output logic [31:0] rdata);
      uart_rx_valid = 1'b1; uart_rx_byte = b;
      start_request = 1'b1; is_write = 1'b0; target_address = 8'h1C; write_value = 32'h0;
      @(negedge clk);
      uart_rx_valid = 1'b0;
      chk("rxp_done", 32'(request_done), 32'h1);
      rdata = fetched_value;
      start_request = 1'b0;
      @(negedge clk);
   endtask

   task automatic spi_xfer(input logic [7:0] tx, input logic [7:0] rx,
                           input logic [3:0] cs_busy, input logic [3:0] cs_idle);
      start_request = 1'b1; is_write = 1'b1; target_address = 8'h10; write_value = {24'h0, tx};
      @(negedge clk);
      chk("spi_start_hi", 32'(spi_start), 32'h1);
      chk("spi_cs_busy", 32'(spi_cs_n), 32'(cs_busy));
      chk("spi_tx_byte", 32'(spi_tx_byte), 32'(tx));
      repeat (9) @(negedge clk);
      chk("spi_wait_nodone", 32'(request_done), 32'h0);
      spi_done = 1'b1; spi_rx_byte = rx;
      @(negedge clk);
      spi_done = 1'b0;
      chk("spi_start_lo", 32'(spi_start), 32'h0);
      chk("spi_req_done", 32'(request_done), 32'h1);
      chk("spi_cs_after", 32'(spi_cs_n), 32'(cs_idle));
      start_request = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      start_request = 1'b0; is_write = 1'b0; target_address = '0; write_value = '0;
      gpio_in = '0; spi_done = 1'b0; spi_rx_byte = '0;
      uart_tx_done = 1'b0; uart_rx_valid = 1'b0; uart_rx_byte = '0;
      last_tx_start = 1'b0;
      #1;
      chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_done", 32'(request_done), 32'h0);
      chk("rst_spi_start", 32'(spi_start), 32'h0);
      chk("rst_tx_start", 32'(uart_tx_start), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // GPIO
      wr(8'h04, 32'h0F);
      wr(8'h00, 32'hFF);
      chk("gpio_out", 32'(gpio_out), 32'h0F);
      chk("gpio_oe", 32'(gpio_oe), 32'h0F);
      gpio_in = 8'hA5;
      repeat (2) @(negedge clk);
      rd_chk("gpio_in_rd", 8'h08, 32'hA0);
      rd_chk("gpio_out_rd", 8'h00, 32'hFF);
      wr(8'h20, 32'h12345678);
      rd_chk("unmapped_rd", 8'h20, 32'h0);
      rd_chk("gpio_out_kept", 8'h00, 32'hFF);

      // SPI, no hold
      wr(8'h0C, 32'h4);
      chk("cs_idle_nohold", 32'(spi_cs_n), 32'hF);
      spi_xfer(8'h3C, 8'h96, 4'b1011, 4'b1111);
      rd_chk("spi_rx_rd", 8'h10, 32'h96);

      // SPI, hold
      wr(8'h0C, 32'h8000_0002);
      chk("cs_hold_idle", 32'(spi_cs_n), 32'hD);
      rd_chk("spi_cs_rd", 8'h0C, 32'h8000_0002);
      spi_xfer(8'h11, 8'h22, 4'b1101, 4'b1101);
      spi_xfer(8'h33, 8'h44, 4'b1101, 4'b1101);
      rd_chk("spi_rx_rd2", 8'h10, 32'h44);
      wr(8'h0C, 32'h0);
      chk("cs_cleared", 32'(spi_cs_n), 32'hF);

      // UART TX with stall
      wr(8'h18, 32'h41);
      chk("tx1_start", 32'(last_tx_start), 32'h1);
      chk("tx1_byte", 32'(uart_tx_byte), 32'h41);
      chk("tx1_pulse_end", 32'(uart_tx_start), 32'h0);
      rd_chk("stat_busy", 8'h14, 32'h1);
      start_request = 1'b1; is_write = 1'b1; target_address = 8'h18; write_value = 32'h42;
      repeat (3) begin
         @(negedge clk);
         chk("txw_no_done", 32'(request_done), 32'h0);
         chk("txw_no_start", 32'(uart_tx_start), 32'h0);
      end
      uart_tx_done = 1'b1;
      @(negedge clk);
      uart_tx_done = 1'b0;
      chk("txw_after_done", 32'(uart_tx_start), 32'h0);
      @(negedge clk);
      chk("tx2_start", 32'(uart_tx_start), 32'h1);
      chk("tx2_byte", 32'(uart_tx_byte), 32'h42);
      chk("tx2_req_done", 32'(request_done), 32'h1);
      start_request = 1'b0;
      @(negedge clk);
      chk("tx2_pulse_end", 32'(uart_tx_start), 32'h0);
      chk("tx2_done_drop", 32'(request_done), 32'h0);
      rd_chk("tx_last_rd", 8'h18, 32'h42);
      uart_tx_done = 1'b1;
      @(negedge clk);
      uart_tx_done = 1'b0;
      rd_chk("stat_idle", 8'h14, 32'h0);

      // RX FIFO overflow
      for (int i = 1; i <= 5; i++) push(8'(i));
      rd_chk("stat_ovf", 8'h14, 32'hE);
      for (int i = 1; i <= 4; i++) rd_chk("rx_pop", 8'h1C, 32'(i));
      rd_chk("rx_empty_rd", 8'h1C, 32'h0);
      rd_chk("stat_ovf_only", 8'h14, 32'h8);
      wr(8'h14, 32'h8);
      rd_chk("stat_ovf_clr", 8'h14, 32'h0);

      // Full FIFO: push and pop same cycle
      for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
      rd_chk("stat_full", 8'h14, 32'h6);
      rx_read_push(8'h15, rd);
      chk("full_pp_rd", rd, 32'h11);
      rd_chk("stat_full_noovf", 8'h14, 32'h6);
      for (int i = 0; i < 4; i++) rd_chk("full_pp_order", 8'h1C, 32'h12 + 32'(i));
      rd_chk("rx_drained", 8'h1C, 32'h0);

      // Empty FIFO: push and pop same cycle
      rx_read_push(8'h77, rd);
      chk("empty_pp_rd", rd, 32'h0);
      rd_chk("stat_one", 8'h14, 32'h2);
      rd_chk("empty_pp_stored", 8'h1C, 32'h77);

      // Async reset during SPI_WAIT
      wr(8'h0C, 32'h4);
      rx_read_push(8'h55, rd);
      push(8'h66);
      start_request = 1'b1; is_write = 1'b1; target_address = 8'h10; write_value = 32'h5A;
      @(negedge clk);
      chk("rst_pre_start", 32'(spi_start), 32'h1);
      chk("rst_pre_cs", 32'(spi_cs_n), 32'hB);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_start", 32'(spi_start), 32'h0);
      chk("rst_mid_done", 32'(request_done), 32'h0);
      chk("rst_mid_cs", 32'(spi_cs_n), 32'hF);
      chk("rst_mid_gpio", 32'(gpio_out), 32'h0);
      @(negedge clk);
      start_request = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      rd_chk("rst_stat", 8'h14, 32'h0);
      rd_chk("rst_rx_empty", 8'h1C, 32'h0);
      rd_chk("rst_gpio_oe", 8'h04, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/io_periph_bus.md
Name: io_periph_bus

Overview:
Parametrised memory-mapped IO register block and the successor to the fixed-width IO decoder. It serves the core's request/done bus for all non-memory addresses. It provides a GPIO bank with per-pin output enable, and an SPI peripheral port with N chip selects and a CS-hold mode. It also provides a UART register interface with a receive FIFO and a sticky overflow flag. SPI and UART bit engines are external and are driven through byte handshakes.

Parameters:
GPIO_W, 8, number of bidirectional GPIO pins (1..32)
NUM_CS, 4, number of SPI peripheral chip selects (1..8)
RX_DEPTH, 4, UART RX FIFO depth in bytes (power of 2, 2..16)
ADDR_W, 8, width of IO byte address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_request  in  1  bus request; held high until request_done seen
is_write  in  1  1 = write, 0 = read
target_address  in  ADDR_W  byte address; bits [1:0] ignored
write_value  in  32  write data
fetched_value  out  32  read data, valid while request_done=1
request_done  out  1  held high until start_request drops
gpio_in  in  GPIO_W  raw pin inputs
gpio_out  out  GPIO_W  pin output values
gpio_oe  out  GPIO_W  per-pin output enable (1 = drive)
spi_cs_n  out  NUM_CS  active-low chip selects
spi_start  out  1  level request to SPI engine
spi_tx_byte  out  8  byte to shift out
spi_done  in  1  1-cycle pulse, transfer complete
spi_rx_byte  in  8  byte shifted in, valid with spi_done
uart_tx_start  out  1  1-cycle start pulse
uart_tx_byte  out  8  byte to send
uart_tx_done  in  1  1-cycle pulse, frame sent
uart_rx_valid  in  1  1-cycle pulse, byte received
uart_rx_byte  in  8  received byte, valid with uart_rx_valid

Behaviour:
- Reset clears all registers and the FIFO. Reset values: outputs 0 except spi_cs_n all 1; state IDLE.
- Reset is asynchronous and takes effect mid-transaction; spi_start and request_done drop immediately.
- Register map (word offsets; unmapped writes ignored, unmapped reads return 0):
  - 0x00 GPIO_OUT rw [GPIO_W-1:0]. gpio_out = GPIO_OUT & gpio_oe.
  - 0x04 GPIO_OE rw.
  - 0x08 GPIO_IN ro. gpio_in passes through a 2-flop synchroniser; read value is masked with ~gpio_oe.
  - 0x0C SPI_CS rw. [NUM_CS-1:0] is the select mask; bit 31 is HOLD. With HOLD=1, masked lines are low continuously. With HOLD=0, masked lines are low only while spi_start=1.
  - 0x10 SPI_DATA. Write starts a transfer. Read returns the last rx byte zero-extended.
  - 0x14 UART_STATUS. Read returns {28'b0, overflow, full, nonempty, tx_busy}. Writing 1 to bit3 clears overflow; other bits are ro.
  - 0x18 UART_TX. A write sends a byte; a read returns the last tx byte.
  - 0x1C UART_RX ro. A read pops the FIFO head, zero-extended; reading an empty FIFO returns 0 and pops nothing.
- FSM states: IDLE, SPI_WAIT, TX_WAIT, DONE.
  - IDLE with start_request=1:
    - SPI_DATA write: latch spi_tx_byte, go to SPI_WAIT.
    - UART_TX write with tx_busy=1: go to TX_WAIT.
    - All other accesses: perform the access, set request_done, go to DONE. Latency is 1 cycle.
  - SPI_WAIT: spi_start=1. On spi_done, capture spi_rx_byte, drop spi_start the next cycle, set request_done, go to DONE.
  - UART_TX write with tx_busy=0: latch the byte, pulse uart_tx_start for 1 cycle, set tx_busy, set done.
  - TX_WAIT: wait for tx_busy=0, then do the same as the tx_busy=0 case.
  - DONE: hold request_done and fetched_value. When start_request=0, clear request_done and go to IDLE.
  - start_request dropping in SPI_WAIT or TX_WAIT is a protocol violation. The block completes the operation, then returns to IDLE.
- tx_busy clears on uart_tx_done. If set and clear land in the same cycle, set wins.
- RX FIFO:
  - Pointers are log2(RX_DEPTH)+1 bits wide and wrap modulo 2*RX_DEPTH.
  - Push on uart_rx_valid. A push when full with no pop drops the byte and sets sticky overflow.
  - A pop happens on an accepted UART_RX read, in the IDLE→DONE cycle only.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Push and pop in the same cycle while empty: the read returns 0 and the push is stored.
  - If uart_rx_valid coincides with an overflow-clear write, the set wins.

Test Plan:
- Write GPIO_OE=0x0F, GPIO_OUT=0xFF → gpio_out=0x0F. Drive gpio_in=0xA5; after 2 cycles a GPIO_IN read returns 0xA0.
- SPI_CS=0x4 (HOLD=0), write SPI_DATA=0x3C, engine pulses spi_done with rx 0x96 after 10 cycles → spi_cs_n=1011 only while spi_start=1; request_done follows; SPI_DATA read returns 0x96.
- SPI_CS=0x8000_0002 → spi_cs_n=1101 between two transfers; writing SPI_CS=0 → spi_cs_n=1111.
- Write UART_TX=0x41, then UART_TX=0x42 before uart_tx_done → second request stalls in TX_WAIT. After uart_tx_done, a second start pulse is issued with byte 0x42.
- Push RX_DEPTH+1 bytes 0x01..0x05 (depth 4) → STATUS=0xE. Four reads return 0x01..0x04, a fifth read returns 0. Write STATUS bit3 → overflow clears.
- Full FIFO: pop and push in the same cycle → overflow stays 0, new byte is last out. Assert rst_n=0 during SPI_WAIT → spi_start and request_done drop immediately, spi_cs_n=all 1.
